// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared hold levels, bus widths, controller state type and counter sizing
package pipe_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int HOLD_W = 3;
  localparam logic [HOLD_W-1:0] HOLD_NONE  = 3'd0;
  localparam logic [HOLD_W-1:0] HOLD_PC    = 3'd1;
  localparam logic [HOLD_W-1:0] HOLD_IF_ID = 3'd2;
  localparam logic [HOLD_W-1:0] HOLD_ID_EX = 3'd3;
  typedef enum logic [1:0] {IDLE, FLUSH, STALL} pipe_ctrl_state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: saturating stall counter with a sticky timeout flag
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int W = cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic timeout
);
  localparam logic [W-1:0] MAX = W'(LIMIT);
  logic [W-1:0] count, base, nxt;
  // clear and enable together restart the count at 1
  assign base = clear ? '0 : count;
  assign nxt = (enable && base != MAX) ? base + 1'b1 : base;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      timeout <= 1'b0;
    end else begin
      count <= nxt;
      timeout <= timeout | (nxt == MAX);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush controller with jump/irq redirect, flush sequence and stall watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_addr_i,
  output logic [HOLD_W-1:0] hold_flag_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              irq_ack_o,
  output logic              timeout_o
);
  localparam int FW = cnt_w(FLUSH_CYCLES);
  pipe_ctrl_state_t state, state_n;
  logic [FW-1:0] flush_cnt, flush_n;
  logic [HOLD_W-1:0] lvl;
  logic in_flush, eval_idle, take_irq, take_jump, redirect, stall_go, stall_cont, timeout_q;
  assign in_flush = state == FLUSH;
  // a STALL cycle whose hold_ex has dropped behaves exactly like IDLE
  assign eval_idle = state == IDLE || (state == STALL && !hold_ex_i);
  assign take_irq = eval_idle && irq_req_i;
  assign take_jump = (eval_idle || in_flush) && jump_flag_i && !take_irq;
  assign redirect = take_irq || take_jump;
  assign stall_go = eval_idle && hold_ex_i && !redirect;
  assign stall_cont = state == STALL && hold_ex_i;
  always_comb begin
    lvl = (redirect || stall_go || stall_cont) ? HOLD_ID_EX : in_flush ? HOLD_IF_ID : HOLD_NONE;
    hold_flag_o = rst_n_i ? HOLD_NONE : (hold_bus_i && lvl < HOLD_PC) ? HOLD_PC : lvl;
    jump_flag_o = !rst_n_i && redirect;
    jump_addr_o = rst_n_i ? '0 : take_irq ? irq_addr_i : take_jump ? jump_addr_i : '0;
    irq_ack_o = !rst_n_i && take_irq;
    timeout_o = !rst_n_i && timeout_q;
    state_n = redirect ? FLUSH
            : (in_flush && flush_cnt != FW'(1)) ? FLUSH
            : (stall_go || stall_cont) ? STALL : IDLE;
    flush_n = redirect ? FW'(FLUSH_CYCLES) : in_flush ? flush_cnt - 1'b1 : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state <= IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      flush_cnt <= flush_n;
    end
  end
  stall_watchdog #(.LIMIT(STALL_TIMEOUT)) u_wdog (
    .clk(clk_i),
    .rst(rst_n_i),
    .enable(stall_go || stall_cont),
    .clear(!stall_cont),
    .timeout(timeout_q)
  );
endmodule
